// File: rtl/intersection_phase_scheduler.sv
// Actuated round-robin phase scheduler for a two-road intersection with a
// pedestrian crossing, min/max green timing and emergency preempt.
module intersection_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALL_RED_T = 1,
  parameter int unsigned WALK_T    = 5,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       ped_walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SRV_NS  = 2'd0,
    SRV_EW  = 2'd1,
    SRV_PED = 2'd2
  } srv_t;

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_GREEN  = 2'b01;
  localparam logic [1:0] L_YELLOW = 2'b10;

  localparam logic [CNT_W-1:0] GMIN_END = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_END = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_END   = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] WALK_END = CNT_W'(WALK_T - 1);

  state_t           state_q, state_d;
  srv_t             last_q, last_d, grant;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ns_pend_q, ns_pend_d;
  logic             ew_pend_q, ew_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_repend;
  logic             entering;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ALL_RED;
      last_q     <= SRV_PED;
      timer_q    <= '0;
      ns_pend_q  <= 1'b0;
      ew_pend_q  <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      ns_pend_q  <= ns_pend_d;
      ew_pend_q  <= ew_pend_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  // Round-robin pick starting after last_q; with nothing pending, rest on NS.
  always_comb begin
    grant = SRV_NS;
    unique case (last_q)
      SRV_NS: begin
        if (ew_pend_q)       grant = SRV_EW;
        else if (ped_pend_q) grant = SRV_PED;
        else                 grant = SRV_NS;
      end
      SRV_EW: begin
        if (ped_pend_q)      grant = SRV_PED;
        else if (ns_pend_q)  grant = SRV_NS;
        else if (ew_pend_q)  grant = SRV_EW;
        else                 grant = SRV_NS;
      end
      default: begin
        if (ns_pend_q)       grant = SRV_NS;
        else if (ew_pend_q)  grant = SRV_EW;
        else if (ped_pend_q) grant = SRV_PED;
        else                 grant = SRV_NS;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    ped_repend = 1'b0;
    unique case (state_q)
      ALL_RED: begin
        if (timer_q == AR_END) begin
          if (emerg_req) begin
            state_d = emerg_dir ? EW_GREEN : NS_GREEN;
          end else begin
            last_d = grant;
            unique case (grant)
              SRV_EW:  state_d = EW_GREEN;
              SRV_PED: state_d = PED_WALK;
              default: state_d = NS_GREEN;
            endcase
          end
        end
      end
      NS_GREEN: begin
        if (emerg_req) begin
          if (emerg_dir) state_d = NS_YELLOW;
        end else if (timer_q >= GMIN_END && (ew_pend_q || ped_pend_q) &&
                     (!ns_req || timer_q >= GMAX_END)) begin
          state_d = NS_YELLOW;
        end
      end
      EW_GREEN: begin
        if (emerg_req) begin
          if (!emerg_dir) state_d = EW_YELLOW;
        end else if (timer_q >= GMIN_END && (ns_pend_q || ped_pend_q) &&
                     (!ew_req || timer_q >= GMAX_END)) begin
          state_d = EW_YELLOW;
        end
      end
      NS_YELLOW, EW_YELLOW: begin
        if (timer_q == YEL_END) state_d = ALL_RED;
      end
      PED_WALK: begin
        if (emerg_req) begin
          state_d    = ALL_RED;
          ped_repend = 1'b1;
        end else if (timer_q == WALK_END) begin
          state_d = ALL_RED;
        end
      end
      default: state_d = ALL_RED;
    endcase
  end

  // Entry into the served phase wins over a request on that same edge.
  always_comb begin
    entering   = (state_d != state_q);
    ns_pend_d  = ns_pend_q;
    ew_pend_d  = ew_pend_q;
    ped_pend_d = ped_pend_q;
    if (entering && state_d == NS_GREEN)        ns_pend_d = 1'b0;
    else if (state_q != NS_GREEN && ns_req)     ns_pend_d = 1'b1;
    if (entering && state_d == EW_GREEN)        ew_pend_d = 1'b0;
    else if (state_q != EW_GREEN && ew_req)     ew_pend_d = 1'b1;
    if (entering && state_d == PED_WALK)        ped_pend_d = 1'b0;
    else if ((state_q != PED_WALK && ped_req) || ped_repend) ped_pend_d = 1'b1;
    if (entering)             timer_d = '0;
    else if (timer_q == '1)   timer_d = timer_q;
    else                      timer_d = timer_q + 1'b1;
  end

  always_comb begin
    ns_light = L_RED;
    ew_light = L_RED;
    ped_walk = 1'b0;
    ped_wait = ped_pend_q;
    phase    = state_q;
    unique case (state_q)
      NS_GREEN:  ns_light = L_GREEN;
      NS_YELLOW: ns_light = L_YELLOW;
      EW_GREEN:  ew_light = L_GREEN;
      EW_YELLOW: ew_light = L_YELLOW;
      PED_WALK:  ped_walk = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Self-checking bench for intersection_phase_scheduler: directed scenarios plus
// randomized traffic checked against a phase/elapsed-time reference model.
module tb_intersection_phase_scheduler;

  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YEL  = 2;
  localparam int AR   = 1;
  localparam int WALK = 5;
  localparam int SERVED [3] = '{1, 3, 5};  // requester 0 NS, 1 EW, 2 PED

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ns_req = 1'b0, ew_req = 1'b0, ped_req = 1'b0;
  logic       emerg_req = 1'b0, emerg_dir = 1'b0;
  logic [1:0] ns_light, ew_light;
  logic       ped_walk, ped_wait;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  intersection_phase_scheduler #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YEL),
    .ALL_RED_T(AR), .WALK_T(WALK), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ns_req(ns_req), .ew_req(ew_req),
    .ped_req(ped_req), .emerg_req(emerg_req), .emerg_dir(emerg_dir),
    .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk),
    .ped_wait(ped_wait), .phase(phase)
  );

  // Reference model: current phase, cycles spent in it, pending flags, last grant.
  int m_phase, m_el, m_last;
  bit m_pend [3];

  function automatic void model_reset();
    m_phase = 0; m_el = 0; m_last = 2;
    for (int r = 0; r < 3; r++) m_pend[r] = 1'b0;
  endfunction

  function automatic void model_step();
    int nx, g, conflicts, own;
    bit found, repend;
    bit req [3];
    req[0] = ns_req; req[1] = ew_req; req[2] = ped_req;
    nx = m_phase; repend = 1'b0;
    case (m_phase)
      0: if (m_el + 1 >= AR) begin
        if (emerg_req) nx = emerg_dir ? 3 : 1;
        else begin
          g = 0; found = 1'b0;
          for (int k = 1; k <= 3; k++)
            if (!found && m_pend[(m_last + k) % 3]) begin g = (m_last + k) % 3; found = 1'b1; end
          nx = SERVED[g]; m_last = g;
        end
      end
      1, 3: begin
        own = (m_phase == 3) ? 1 : 0;
        conflicts = 0;
        for (int r = 0; r < 3; r++) if (r != own && m_pend[r]) conflicts++;
        if (emerg_req) begin
          if (int'(emerg_dir) != own) nx = m_phase + 1;
        end else if (m_el + 1 >= GMIN && conflicts > 0 && (!req[own] || m_el + 1 >= GMAX))
          nx = m_phase + 1;
      end
      2, 4: if (m_el + 1 >= YEL) nx = 0;
      default: if (emerg_req) begin nx = 0; repend = 1'b1; end
               else if (m_el + 1 >= WALK) nx = 0;
    endcase
    for (int r = 0; r < 3; r++) begin
      if (nx == SERVED[r] && m_phase != SERVED[r]) m_pend[r] = 1'b0;
      else if (m_phase != SERVED[r] && req[r]) m_pend[r] = 1'b1;
    end
    if (repend) m_pend[2] = 1'b1;
    m_el = (nx != m_phase) ? 0 : m_el + 1;
    m_phase = nx;
  endfunction

  function automatic logic [8:0] m_out();
    logic [1:0] nl, el;
    nl = (m_phase == 1) ? 2'b01 : (m_phase == 2) ? 2'b10 : 2'b00;
    el = (m_phase == 3) ? 2'b01 : (m_phase == 4) ? 2'b10 : 2'b00;
    return {nl, el, (m_phase == 5), m_pend[2], 3'(m_phase)};
  endfunction

  function automatic logic [8:0] dut_out();
    return {ns_light, ew_light, ped_walk, ped_wait, phase};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    ns_req = 0; ew_req = 0; ped_req = 0; emerg_req = 0; emerg_dir = 0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    ns_req = 0; ew_req = 0; ped_req = 0; emerg_req = 0; emerg_dir = 0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    n_tests++;
    if (dut_out() !== 9'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", dut_out(), 9'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    n_tests++;
    if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase0: got %0d expected 0", phase); end
    tick();
    n_tests++;
    if (ns_light !== 2'b01) begin n_fail++; $display("FAIL rest_first_green: got %b expected 01", ns_light); end
    for (int i = 0; i < 300; i++) begin
      tick();
      n_tests++;
      if (dut_out() !== m_out()) begin
        n_fail++; $display("FAIL rest_hold t=%0d: got %b expected %b", i, dut_out(), m_out());
      end
    end
    n_tests++;
    if ({ns_light, ew_light, ped_walk} !== 5'b01000) begin
      n_fail++; $display("FAIL rest_saturated: got %b expected 01000", {ns_light, ew_light, ped_walk});
    end
  endtask

  task automatic test_ped_service();
    int exp_seq [12] = '{1, 2, 2, 0, 5, 5, 5, 5, 5, 0, 1, 1};
    do_reset();
    tick(); tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    n_tests++;
    if (ped_wait !== 1'b1) begin n_fail++; $display("FAIL ped_wait_set: got %b expected 1", ped_wait); end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (phase !== 3'(exp_seq[i]) || dut_out() !== m_out()) begin
        n_fail++;
        $display("FAIL ped_seq i=%0d: got phase %0d out %b expected phase %0d out %b",
                 i, phase, dut_out(), exp_seq[i], m_out());
      end
    end
  endtask

  task automatic test_max_out();
    int exp_seq [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 0, 3};
    do_reset();
    tick();
    ns_req = 1'b1; ew_req = 1'b1;
    tick();
    ew_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (phase !== 3'(exp_seq[i]) || dut_out() !== m_out()) begin
        n_fail++;
        $display("FAIL maxout_seq i=%0d: got phase %0d out %b expected phase %0d out %b",
                 i, phase, dut_out(), exp_seq[i], m_out());
      end
    end
    ns_req = 1'b0;
  endtask

  task automatic test_rr_order();
    int grants [$];
    int exp_g [3] = '{3, 5, 1};
    logic [2:0] prev;
    do_reset();
    tick();
    ew_req = 1'b1; ped_req = 1'b1;
    tick();
    ew_req = 1'b0; ped_req = 1'b0;
    for (int b = 0; b < 20 && phase != 3'd2; b++) tick();
    n_tests++;
    if (phase !== 3'd2) begin n_fail++; $display("FAIL rr_reach_yellow: got %0d expected 2", phase); end
    ns_req = 1'b1;
    tick();
    ns_req = 1'b0;
    prev = phase;
    for (int b = 0; b < 80 && grants.size() < 3; b++) begin
      tick();
      n_tests++;
      if (dut_out() !== m_out()) begin
        n_fail++; $display("FAIL rr_model b=%0d: got %b expected %b", b, dut_out(), m_out());
      end
      if (prev == 3'd0 && phase != 3'd0) grants.push_back(int'(phase));
      prev = phase;
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (k >= grants.size() || grants[k] != exp_g[k]) begin
        n_fail++;
        $display("FAIL rr_grant k=%0d: got %0d expected %0d", k,
                 (k < grants.size()) ? grants[k] : -1, exp_g[k]);
      end
    end
  endtask

  task automatic test_preempt();
    int exp_p, ew_len;
    do_reset();
    tick(); tick();
    emerg_req = 1'b1; emerg_dir = 1'b1; ns_req = 1'b1;
    ew_len = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_p = (k <= 2) ? 2 : (k == 3) ? 0 : 3;
      if (phase == 3'd3) ew_len++;
      n_tests++;
      if (phase !== 3'(exp_p) || dut_out() !== m_out()) begin
        n_fail++;
        $display("FAIL preempt_seq k=%0d: got phase %0d out %b expected phase %0d out %b",
                 k, phase, dut_out(), exp_p, m_out());
      end
    end
    emerg_req = 1'b0;
    for (int b = 0; b < 20 && phase != 3'd1; b++) begin
      tick();
      n_tests++;
      if (dut_out() !== m_out()) begin
        n_fail++; $display("FAIL preempt_release b=%0d: got %b expected %b", b, dut_out(), m_out());
      end
    end
    n_tests++;
    if (phase !== 3'd1 || ew_len < GMIN) begin
      n_fail++; $display("FAIL preempt_ns_served: got phase %0d ew_len %0d expected phase 1 ew_len>=%0d",
                         phase, ew_len, GMIN);
    end
    ns_req = 1'b0;
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    tick(); tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    for (int b = 0; b < 20 && phase != 3'd5; b++) tick();
    n_tests++;
    if (phase !== 3'd5) begin n_fail++; $display("FAIL midwalk_reach: got %0d expected 5", phase); end
    ns_req = 1'b1; ew_req = 1'b1; ped_req = 1'b1;
    tick();
    ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (dut_out() !== 9'b0) begin
      n_fail++; $display("FAIL midwalk_async_reset: got %b expected %b", dut_out(), 9'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    n_tests++;
    if (phase !== 3'd0) begin n_fail++; $display("FAIL midwalk_rel_phase: got %0d expected 0", phase); end
    for (int i = 0; i < 30; i++) begin
      tick();
      n_tests++;
      if (ns_light !== 2'b01 || dut_out() !== m_out()) begin
        n_fail++; $display("FAIL midwalk_rest i=%0d: got %b expected %b", i, dut_out(), m_out());
      end
    end
  endtask

  task automatic test_random();
    int emerg_left = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) ns_req = ~ns_req;
      if ($urandom_range(9) == 0) ew_req = ~ew_req;
      ped_req = ($urandom_range(14) == 0);
      if (emerg_left > 0) emerg_left--;
      else if ($urandom_range(149) == 0) begin
        emerg_left = $urandom_range(25, 1);
        emerg_dir  = 1'($urandom_range(1));
      end
      emerg_req = (emerg_left > 0);
      tick();
      n_tests++;
      if (dut_out() !== m_out()) begin
        n_fail++; $display("FAIL random i=%0d: got %b expected %b", i, dut_out(), m_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_ped_service();
    test_max_out();
    test_rr_order();
    test_preempt();
    test_reset_mid_walk();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Actuated phase scheduler for a two-road intersection with a pedestrian crossing. It shares the crossing between three requesters: north-south vehicles, east-west vehicles and pedestrians. It latches requests and grants them round-robin, with min/max green timing and an emergency-vehicle preempt. It drives the light encodings consumed by the signal-head drivers and sits above the per-head light logic.

Parameters:
GREEN_MIN, 4, minimum green duration in clk cycles (>=1)
GREEN_MAX, 10, maximum green duration while a conflicting request is pending (>=GREEN_MIN)
YELLOW_T, 2, yellow duration in cycles (>=1)
ALL_RED_T, 1, all-red clearance duration in cycles (>=1)
WALK_T, 5, pedestrian walk duration in cycles (>=1)
CNT_W, 8, phase timer width; must hold GREEN_MAX

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  reset; one clock; reset is asynchronous and active-low
ns_req  input  1  north-south vehicle sensor, level
ew_req  input  1  east-west vehicle sensor, level
ped_req  input  1  pedestrian button, pulse or level
emerg_req  input  1  emergency preempt, level
emerg_dir  input  1  preempt direction: 0=NS, 1=EW; sampled while emerg_req=1
ns_light  output  2  00 red, 01 green, 10 yellow (11 unused)
ew_light  output  2  same encoding
ped_walk  output  1  1 in PED_WALK
ped_wait  output  1  pedestrian request latched, not yet served
phase  output  3  0 ALL_RED, 1 NS_GREEN, 2 NS_YELLOW, 3 EW_GREEN, 4 EW_YELLOW, 5 PED_WALK

Behaviour:
- Moore outputs decoded from the state register; they change on the same edge as the state.
- Reset (async assert): state ALL_RED, timer=0, all pend flags=0, last_served=PED. Outputs: ns_light=00, ew_light=00, ped_walk=0, ped_wait=0, phase=0. Reset asserted mid-phase forces these values immediately.
- Timer clears on every state entry and increments each cycle in a state, saturating at 2^CNT_W-1. A timed state with duration T exits on the edge where timer==T-1, so it lasts exactly T cycles.
- Pending latches: ns_pend is set by ns_req in any state except NS_GREEN; ew_pend likewise for EW_GREEN; ped_pend for PED_WALK. Each flag clears on entry to its served state. ped_wait=ped_pend.
- ALL_RED lasts ALL_RED_T cycles, then:
  - if preempt is latched: the emerg_dir green.
  - else the first pending requester in round-robin order NS->EW->PED, starting after last_served.
  - if none is pending: NS_GREEN (main-road rest).
  - last_served updates on grant.
- NS_GREEN/EW_GREEN:
  - Exit to the matching YELLOW when timer>=GREEN_MIN-1 and another pend flag is set, and either the own sensor is low (gap-out) or timer==GREEN_MAX-1 (max-out).
  - With no conflicting pend flag, hold green indefinitely; the timer saturates.
- YELLOW lasts YELLOW_T cycles, then ALL_RED. PED_WALK lasts WALK_T cycles, then ALL_RED.
- Preempt, when emerg_req=1:
  - Green in the conflicting direction: go to YELLOW on the next edge, ignoring GREEN_MIN.
  - PED_WALK: go to ALL_RED on the next edge; ped_pend is re-set so the walk is re-served later.
  - Green in the requested direction: held regardless of GREEN_MAX while emerg_req=1.
  - Yellow and all-red are never shortened.
  - A preempt-granted green is not a round-robin grant; last_served is unchanged.
  - When emerg_req falls, normal green rules resume with the current timer.
- Simultaneous events:
  - Preempt beats round-robin.
  - A request arriving on the grant edge of its own phase is not latched.
  - Requests during yellow or all-red are latched normally.

Test Plan:
- Release reset, no requests, defaults -> phase 0 for 1 cycle, then ns_light=01 held indefinitely; ew_light=00, ped_walk=0.
- At NS_GREEN cycle 1, 1-cycle ped_req pulse, ns_req low -> ped_wait=1. NS green 4 cycles, yellow 2, all-red 1, ped_walk=1 for 5 cycles, all-red 1, then NS_GREEN; ped_wait clears on walk entry.
- ns_req held high, ew_req pulsed at NS green cycle 0 -> NS green lasts exactly 10 cycles (max-out), then yellow 2, all-red 1, then ew_light=01.
- ns_pend, ew_pend and ped_pend all set during all-red with last_served=NS -> grant order EW, PED, NS.
- emerg_req=1, emerg_dir=1 at NS green cycle 1 -> NS yellow next edge (2 cycles), all-red 1, EW green held for all 20 cycles emerg_req stays high despite ns_req=1. After release, NS served once EW green has lasted >=4 cycles.
- Assert reset_n=0 during PED_WALK cycle 2 with pending flags set -> outputs immediately all-red, ped_walk=0, ped_wait=0. After release, same sequence as the first scenario.
